// File: rtl/alu_exec_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the ALU execute controller.
// Also sizes the wait counter from the multicycle latencies.
package alu_exec_ctrl_pkg;

   typedef enum logic [2:0] {
      OC_ADD = 3'd0,
      OC_SUB = 3'd1,
      OC_MUL = 3'd2,
      OC_DIV = 3'd3,
      OC_NOT = 3'd4,
      OC_XOR = 3'd5,
      OC_OR  = 3'd6,
      OC_AND = 3'd7
   } oc_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic int cnt_width(input int mul_c, input int div_c);
      int mx;
      mx = (mul_c > div_c) ? mul_c : div_c;
      return (mx > 1) ? $clog2(mx) : 1;
   endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Request and result valid/ready bundle for the ALU execute controller.
// master = requester/consumer side, slave = controller side.
interface alu_exec_ctrl_if #(
   parameter int DATA_WIDTH = 16
);

   logic                  req_valid;
   logic                  req_ready;
   logic [2:0]            req_oc;
   logic [DATA_WIDTH-1:0] req_a;
   logic [DATA_WIDTH-1:0] req_b;
   logic                  res_valid;
   logic                  res_ready;
   logic [DATA_WIDTH-1:0] res_data;
   logic                  res_zero;
   logic                  res_neg;
   logic                  res_dbz;

   modport master (
      output req_valid, req_oc, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_data,
      input  res_zero, res_neg, res_dbz
   );

   modport slave (
      input  req_valid, req_oc, req_a, req_b, res_ready,
      output req_ready, res_valid, res_data,
      output res_zero, res_neg, res_dbz
   );

endinterface

// File: rtl/exec_wait_cnt.sv
// Loadable down-counter timing the multicycle ALU paths.
// Holds at zero; zero flag marks the capture cycle.
module exec_wait_cnt #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multicycle execute controller wrapped around an external combinational ALU.
// Define ALU_EXEC_FLAGS_EN to register res_zero/res_neg/res_dbz; else they read 0.
module alu_exec_ctrl
   import alu_exec_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alu_exec_ctrl_if.slave        bus,
   output logic [2:0]            alu_oc,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   input  logic [DATA_WIDTH-1:0] alu_f,
   output logic                  busy
);

   localparam int CW = cnt_width(MUL_CYCLES, DIV_CYCLES);

   state_e                state;
   state_e                state_n;
   logic                  accept;
   logic                  capture;
   logic                  cnt_zero;
   logic                  dbz;
   logic [CW-1:0]         load_val;
   logic [DATA_WIDTH-1:0] res_data;

   // Divide by zero is judged from the latched operands, not the live request
   assign dbz = (alu_oc == OC_DIV) && (alu_b == '0);

   always_comb begin
      load_val = '0;
      unique case (1'b1)
         (bus.req_oc == OC_MUL):
            load_val = CW'(MUL_CYCLES - 1);
         (bus.req_oc == OC_DIV) && (bus.req_b != '0):
            load_val = CW'(DIV_CYCLES - 1);
         default:
            load_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      capture = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.req_valid) begin
               accept  = 1'b1;
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_zero) begin
               capture = 1'b1;
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.res_ready) begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   exec_wait_cnt #(
      .WIDTH(CW)
   ) u_wait_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .load_val (load_val),
      .en       (state == S_WAIT),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_oc   <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         res_data <= '0;
      end else begin
         if (accept) begin
            alu_oc <= bus.req_oc;
            alu_a  <= bus.req_a;
            alu_b  <= bus.req_b;
         end
         if (capture) begin
            res_data <= dbz ? '1 : alu_f;
         end
      end
   end

`ifdef ALU_EXEC_FLAGS_EN
   logic leave;
   logic zero_q;
   logic neg_q;
   logic dbz_q;

   assign leave = (state == S_DONE) && bus.res_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
         dbz_q  <= 1'b0;
      end else if (capture) begin
         zero_q <= dbz ? 1'b0 : (alu_f == '0);
         neg_q  <= dbz ? 1'b1 : alu_f[DATA_WIDTH-1];
         dbz_q  <= dbz;
      end else if (leave) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
         dbz_q  <= 1'b0;
      end
   end

   assign bus.res_zero = zero_q;
   assign bus.res_neg  = neg_q;
   assign bus.res_dbz  = dbz_q;
`else
   assign bus.res_zero = 1'b0;
   assign bus.res_neg  = 1'b0;
   assign bus.res_dbz  = 1'b0;
`endif

   assign bus.req_ready = (state == S_IDLE);
   assign bus.res_valid = (state == S_DONE);
   assign bus.res_data  = res_data;
   assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Randomized self-checking bench for alu_exec_ctrl with a behavioural ALU.
// Expected results, latencies and flags come from a reference model.
module tb_alu_exec_ctrl;

   localparam int DW  = 16;
   localparam int MUL = 2;
   localparam int DIV = 8;
`ifdef ALU_EXEC_FLAGS_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [2:0]    alu_oc;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [DW-1:0] alu_f;
   logic          busy;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   alu_exec_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   alu_exec_ctrl #(
      .DATA_WIDTH(DW),
      .MUL_CYCLES(MUL),
      .DIV_CYCLES(DIV)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .alu_oc (alu_oc),
      .alu_a  (alu_a),
      .alu_b  (alu_b),
      .alu_f  (alu_f),
      .busy   (busy)
   );

   // Stand-in ALU; a bogus divide-by-zero value proves the override
   function automatic logic [DW-1:0] ref_alu(input logic [2:0] oc,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      logic [2*DW-1:0] p;
      p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      case (oc)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return p[DW-1:0];
         3'd3: return (b == '0) ? 16'h1234 : a / b;
         3'd4: return ~a;
         3'd5: return a ^ b;
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   assign alu_f = ref_alu(alu_oc, alu_a, alu_b);

   function automatic logic [DW-1:0] exp_res(input logic [2:0] oc,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      if (oc == 3'd3 && b == '0) return '1;
      return ref_alu(oc, a, b);
   endfunction

   function automatic int exp_lat(input logic [2:0] oc, input logic [DW-1:0] b);
      if (oc == 3'd2) return MUL;
      if (oc == 3'd3 && b != '0) return DIV;
      return 1;
   endfunction

   function automatic logic [2:0] exp_flags(input logic [2:0] oc,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
      logic [DW-1:0] r;
      r = exp_res(oc, a, b);
      return {FL && (r == '0), FL && r[DW-1], FL && (oc == 3'd3) && (b == '0)};
   endfunction

   task automatic start_op(input logic [2:0] oc, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, output int lat);
      int w;
      w = 0;
      bus.req_valid = 1'b1;
      bus.req_oc    = oc;
      bus.req_a     = a;
      bus.req_b     = b;
      while (!bus.req_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      lat = 0;
      while (!bus.res_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic finish_op();
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got=%b exp=1", bus.req_ready);
      end
      checks++;
      if ({bus.res_valid, busy, alu_oc, alu_a, alu_b, bus.res_data,
           bus.res_zero, bus.res_neg, bus.res_dbz} !== '0) begin
         errors++;
         $display("FAIL reset_outs got v=%b busy=%b oc=%h a=%h b=%h d=%h exp=0",
                  bus.res_valid, busy, alu_oc, alu_a, alu_b, bus.res_data);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_wait();
      int seen;
      bus.req_valid = 1'b1;
      bus.req_oc    = 3'd3;
      bus.req_a     = 16'd100;
      bus.req_b     = 16'd7;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL midwait_busy got=%b exp=1", busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.res_valid, busy, alu_oc, alu_a, alu_b, bus.res_data} !== '0
          || bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL midwait_async got v=%b busy=%b rdy=%b oc=%h a=%h b=%h exp=0/rdy1",
                  bus.res_valid, busy, bus.req_ready, alu_oc, alu_a, alu_b);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.res_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL midwait_noresult got=%0d valid cycles exp=0", seen);
      end
   endtask

   task automatic test_add();
      int lat;
      start_op(3'd0, 16'h0003, 16'h0004, lat);
      checks++;
      if (lat != 1) begin
         errors++;
         $display("FAIL add_lat got=%0d exp=1", lat);
      end
      checks++;
      if (bus.res_data !== 16'h0007 || {bus.res_zero, bus.res_neg} !== 2'b00) begin
         errors++;
         $display("FAIL add_data got=%h z=%b n=%b exp=0007 z=0 n=0",
                  bus.res_data, bus.res_zero, bus.res_neg);
      end
      finish_op();
      checks++;
      if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL add_release got v=%b rdy=%b exp=0/1", bus.res_valid, bus.req_ready);
      end
   endtask

   task automatic test_mul();
      int lat;
      start_op(3'd2, 16'd300, 16'd300, lat);
      checks++;
      if (lat != MUL) begin
         errors++;
         $display("FAIL mul_lat got=%0d exp=%0d", lat, MUL);
      end
      checks++;
      if (bus.res_data !== 16'h5F90) begin
         errors++;
         $display("FAIL mul_data got=%h exp=5f90", bus.res_data);
      end
      finish_op();
   endtask

   task automatic test_dbz();
      int lat;
      start_op(3'd3, 16'd100, 16'd0, lat);
      checks++;
      if (lat != 1) begin
         errors++;
         $display("FAIL dbz_lat got=%0d exp=1", lat);
      end
      checks++;
      if (bus.res_data !== 16'hFFFF || bus.res_dbz !== FL) begin
         errors++;
         $display("FAIL dbz_data got=%h dbz=%b exp=ffff dbz=%b",
                  bus.res_data, bus.res_dbz, FL);
      end
      finish_op();
      checks++;
      if ({bus.res_zero, bus.res_neg, bus.res_dbz} !== 3'b000) begin
         errors++;
         $display("FAIL dbz_flagclr got=%b exp=000",
                  {bus.res_zero, bus.res_neg, bus.res_dbz});
      end
   endtask

   task automatic test_stall();
      int lat;
      start_op(3'd1, 16'd5, 16'd5, lat);
      for (int i = 0; i < 4; i++) begin
         bus.req_valid = 1'b1;
         bus.req_oc    = 3'd0;
         bus.req_a     = 16'd1;
         bus.req_b     = 16'd2;
         checks++;
         if (bus.res_valid !== 1'b1 || bus.req_ready !== 1'b0
             || bus.res_data !== 16'h0000 || bus.res_zero !== FL) begin
            errors++;
            $display("FAIL stall_hold[%0d] got v=%b rdy=%b d=%h z=%b exp=1/0/0000/%b",
                     i, bus.res_valid, bus.req_ready, bus.res_data, bus.res_zero, FL);
         end
         @(posedge clk); #1;
      end
      bus.req_valid = 1'b0;
      checks++;
      if (alu_oc !== 3'd1 || alu_a !== 16'd5) begin
         errors++;
         $display("FAIL stall_ignore got oc=%h a=%h exp=1/0005", alu_oc, alu_a);
      end
      finish_op();
   endtask

   task automatic test_back_to_back();
      int lat;
      int idle;
      start_op(3'd3, 16'd9, 16'd3, lat);
      checks++;
      if (lat != DIV || bus.res_data !== 16'h0003) begin
         errors++;
         $display("FAIL b2b_div got lat=%0d d=%h exp lat=%0d d=0003",
                  lat, bus.res_data, DIV);
      end
      bus.res_ready = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_oc    = 3'd5;
      bus.req_a     = 16'hFF00;
      bus.req_b     = 16'h0FF0;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      idle = 0;
      while (!busy && idle < 10) begin
         idle++;
         @(posedge clk); #1;
      end
      bus.req_valid = 1'b0;
      checks++;
      if (idle != 1) begin
         errors++;
         $display("FAIL b2b_idle got=%0d exp=1", idle);
      end
      lat = 0;
      while (!bus.res_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      checks++;
      if (lat != 1 || bus.res_data !== 16'hF0F0) begin
         errors++;
         $display("FAIL b2b_xor got lat=%0d d=%h exp lat=1 d=f0f0", lat, bus.res_data);
      end
      finish_op();
   endtask

   task automatic test_random();
      int            lat;
      int            stall;
      logic [2:0]    oc;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] er;
      logic [2:0]    ef;
      for (int n = 0; n < 40; n++) begin
         oc    = 3'($urandom_range(0, 7));
         a     = 16'($urandom);
         b     = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
         stall = $urandom_range(0, 2);
         er    = exp_res(oc, a, b);
         ef    = exp_flags(oc, a, b);
         start_op(oc, a, b, lat);
         checks++;
         if (lat != exp_lat(oc, b)) begin
            errors++;
            $display("FAIL rnd_lat[%0d] oc=%0d got=%0d exp=%0d", n, oc, lat, exp_lat(oc, b));
         end
         repeat (stall) begin
            @(posedge clk); #1;
         end
         checks++;
         if (bus.res_valid !== 1'b1 || bus.res_data !== er
             || {bus.res_zero, bus.res_neg, bus.res_dbz} !== ef) begin
            errors++;
            $display("FAIL rnd_res[%0d] oc=%0d a=%h b=%h got v=%b d=%h f=%b exp d=%h f=%b",
                     n, oc, a, b, bus.res_valid, bus.res_data,
                     {bus.res_zero, bus.res_neg, bus.res_dbz}, er, ef);
         end
         finish_op();
      end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_oc    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.res_ready = 1'b0;
      test_reset();
      test_reset_mid_wait();
      test_add();
      test_mul();
      test_dbz();
      test_stall();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
